// File: rtl/op_cmd_sequencer_pkg.sv
// Shared types and defaults for the command-driven AND/OR sequencer.
// Used by the sequencer, its ALU and its bus interface.
package op_cmd_sequencer_pkg;
  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 3;
  localparam int CNT_W_DEF  = 8;

  localparam logic MODE_AND = 1'b0;
  localparam logic MODE_OR  = 1'b1;

  typedef enum logic [2:0] {IDLE, RD_A, RD_B, EXEC, WR} state_e;
endpackage

// File: rtl/op_cmd_sequencer_if.sv
// Command handshake plus the single-port scratch-memory bus.
// slave = sequencer side, master = command source / memory side.
interface op_cmd_sequencer_if
  import op_cmd_sequencer_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [ADDR_W-1:0] cmd_a_addr;
  logic [ADDR_W-1:0] cmd_b_addr;
  logic [ADDR_W-1:0] cmd_c_addr;
  logic              cmd_mode;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_rdata;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_wmode;

  modport slave (
    input  cmd_valid, cmd_a_addr, cmd_b_addr, cmd_c_addr, cmd_mode, mem_rdata,
    output cmd_ready, mem_addr, mem_wdata, mem_wmode
  );
  modport master (
    output cmd_valid, cmd_a_addr, cmd_b_addr, cmd_c_addr, cmd_mode, mem_rdata,
    input  cmd_ready, mem_addr, mem_wdata, mem_wmode
  );
endinterface

// File: rtl/op_cmd_sequencer_alu.sv
// Combinational bitwise AND/OR of two operand words.
module op_alu
  import op_cmd_sequencer_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  input  logic              mode_i,
  output logic [DATA_W-1:0] y_o
);
  assign y_o = (mode_i == MODE_OR) ? (a_i | b_i) : (a_i & b_i);
endmodule

// File: rtl/op_cmd_sequencer.sv
// Accepts one command at a time, reads A then B, computes AND/OR and
// writes the result back; five cycles per command including accept.
module op_cmd_sequencer
  import op_cmd_sequencer_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  op_cmd_sequencer_if.slave  bus,
  output logic               done_o,
  output logic [DATA_W-1:0]  result_o,
  output logic               busy_o,
  output logic [CNT_W-1:0]   op_count_o
);
  typedef struct packed {
    logic [ADDR_W-1:0] a;
    logic [ADDR_W-1:0] b;
    logic [ADDR_W-1:0] c;
    logic              mode;
  } cmd_t;

  state_e             state_q, state_d;
  cmd_t               cmd_q, cmd_d;
  logic [DATA_W-1:0]  a_q, a_d, b_q, b_d, res_q, res_d, alu_y;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               ready;
  logic [ADDR_W-1:0]  addr;
  logic [DATA_W-1:0]  wdata;
  logic               wmode, done;

  op_alu #(.DATA_W(DATA_W)) u_alu (
    .a_i   (a_q),
    .b_i   (b_q),
    .mode_i(cmd_q.mode),
    .y_o   (alu_y)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cmd_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
    end
  end

  // Memory outputs decode from state, so reset clears them (and the write) at once.
  always_comb begin
    state_d = state_q;
    cmd_d   = cmd_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    cnt_d   = cnt_q;
    ready   = 1'b0;
    addr    = '0;
    wdata   = '0;
    wmode   = 1'b0;
    done    = 1'b0;
    case (state_q)
      IDLE: begin
        ready = 1'b1;
        if (bus.cmd_valid) begin
          cmd_d   = '{a: bus.cmd_a_addr, b: bus.cmd_b_addr,
                      c: bus.cmd_c_addr, mode: bus.cmd_mode};
          state_d = RD_A;
        end
      end
      RD_A: begin
        addr    = cmd_q.a;
        a_d     = bus.mem_rdata;
        state_d = RD_B;
      end
      RD_B: begin
        addr    = cmd_q.b;
        b_d     = bus.mem_rdata;
        state_d = EXEC;
      end
      EXEC: begin
        addr    = cmd_q.c;
        res_d   = alu_y;
        state_d = WR;
      end
      WR: begin
        addr    = cmd_q.c;
        wdata   = res_q;
        wmode   = 1'b1;
        done    = 1'b1;
        cnt_d   = cnt_q + 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.cmd_ready = ready & ~rst;
  assign bus.mem_addr  = addr;
  assign bus.mem_wdata = wdata;
  assign bus.mem_wmode = wmode;
  assign done_o        = done;
  assign result_o      = res_q;
  assign busy_o        = (state_q != IDLE);
  assign op_count_o    = cnt_q;
endmodule

// File: tb/tb_op_cmd_sequencer.sv
// Self-checking bench: randomized and directed commands against a
// cycle-countdown reference model with its own shadow memory.
module tb_op_cmd_sequencer;
  localparam int AW = 3;
  localparam int DW = 32;
  localparam int CW = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic          done_o, busy_o;
  logic [DW-1:0] result_o;
  logic [CW-1:0] op_count_o;

  op_cmd_sequencer_if #(.ADDR_W(AW), .DATA_W(DW)) ifc ();

  op_cmd_sequencer #(.DATA_W(DW), .ADDR_W(AW), .CNT_W(CW)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (ifc.slave),
    .done_o    (done_o),
    .result_o  (result_o),
    .busy_o    (busy_o),
    .op_count_o(op_count_o)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Scratch memory (environment) with a preload port
  logic [DW-1:0] mem [8];
  logic          pl_en = 1'b0;
  logic [AW-1:0] pl_addr = '0;
  logic [DW-1:0] pl_data = '0;

  assign ifc.mem_rdata = mem[ifc.mem_addr];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (pl_en) mem[pl_addr] <= pl_data;
    else if (ifc.mem_wmode) mem[ifc.mem_addr] <= ifc.mem_wdata;
  end

  // Reference model: a command occupies four cycles after its accept cycle,
  // the result appears after the third and is written during the fourth.
  logic [DW-1:0] ref_mem [8];
  int            m_left = 0;
  logic [CW-1:0] m_cnt = '0;
  logic [DW-1:0] m_res = '0, m_exp = '0;
  logic [AW-1:0] m_a = '0, m_b = '0, m_c = '0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_left = 0;
      m_cnt  = '0;
      m_res  = '0;
    end else begin
      if (pl_en) ref_mem[pl_addr] = pl_data;
      if (m_left != 0) begin
        if (m_left == 2) m_res = m_exp;
        if (m_left == 1) begin
          ref_mem[m_c] = m_res;
          m_cnt = m_cnt + 1'b1;
        end
        m_left--;
      end else if (ifc.cmd_valid) begin
        m_a = ifc.cmd_a_addr;
        m_b = ifc.cmd_b_addr;
        m_c = ifc.cmd_c_addr;
        m_exp = ifc.cmd_mode ? (ref_mem[m_a] | ref_mem[m_b]) : (ref_mem[m_a] & ref_mem[m_b]);
        m_left = 4;
      end
    end
  end

  int done_cycs[$];
  logic [AW-1:0] exp_addr;

  always @(negedge clk) begin
    if (rst) begin
      chk("rst_ready", ifc.cmd_ready, 0);
      chk("rst_busy", busy_o, 0);
      chk("rst_done", done_o, 0);
      chk("rst_wmode", ifc.mem_wmode, 0);
      chk("rst_count", op_count_o, 0);
      chk("rst_result", result_o, 0);
      chk("rst_addr", ifc.mem_addr, 0);
    end else begin
      chk("ready", ifc.cmd_ready, m_left == 0);
      chk("busy", busy_o, m_left != 0);
      chk("done", done_o, m_left == 1);
      chk("wmode", ifc.mem_wmode, m_left == 1);
      chk("op_count", op_count_o, m_cnt);
      chk("result", result_o, m_res);
      case (m_left)
        4:       exp_addr = m_a;
        3:       exp_addr = m_b;
        2, 1:    exp_addr = m_c;
        default: exp_addr = '0;
      endcase
      chk("mem_addr", ifc.mem_addr, exp_addr);
      if (m_left == 1) chk("wdata", ifc.mem_wdata, m_res);
      if (done_o) done_cycs.push_back(cyc);
    end
  end

  int acc_cyc;

  task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    @(posedge clk); #1;
    pl_en = 1'b0;
  endtask

  task automatic issue(input logic [AW-1:0] a, b, c, input logic m, input bit keep);
    bit got = 0;
    ifc.cmd_a_addr = a; ifc.cmd_b_addr = b; ifc.cmd_c_addr = c;
    ifc.cmd_mode = m; ifc.cmd_valid = 1'b1;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (ifc.cmd_ready) begin got = 1; acc_cyc = cyc; end
    end
    chk("accept_timeout", got, 1);
    @(posedge clk); #1;
    if (!keep) begin
      ifc.cmd_valid  = 1'b0;
      ifc.cmd_a_addr = AW'($urandom); ifc.cmd_b_addr = AW'($urandom);
      ifc.cmd_c_addr = AW'($urandom); ifc.cmd_mode = 1'($urandom);
    end else begin
      // fields the sequencer has already latched are scrambled while it is busy
      ifc.cmd_a_addr = AW'($urandom); ifc.cmd_c_addr = AW'($urandom);
    end
  endtask

  task automatic wait_idle();
    bit idle = 0;
    for (int i = 0; i < 20 && !idle; i++) begin
      @(negedge clk);
      if (m_left == 0 && !busy_o) idle = 1;
    end
    chk("idle_timeout", idle, 1);
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    ifc.cmd_valid = 1'b0; ifc.cmd_a_addr = '0; ifc.cmd_b_addr = '0;
    ifc.cmd_c_addr = '0; ifc.cmd_mode = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("idle_ready", ifc.cmd_ready, 1);
    chk("idle_busy", busy_o, 0);
    chk("idle_count", op_count_o, 0);
    @(posedge clk); #1;
    for (int i = 0; i < 8; i++) preload(AW'(i), $urandom);

    // Reset during RD_B: no write, target untouched, counter stays 0
    preload(3'd7, 32'h7777_7777);
    issue(3'd1, 3'd2, 3'd7, 1'b1, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_wmode", ifc.mem_wmode, 0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("midrst_mem", mem[7], 32'h7777_7777);
    chk("midrst_count", op_count_o, 0);
    chk("midrst_busy", busy_o, 0);
    @(posedge clk); #1;

    // AND command with latency check
    preload(3'd1, 32'hF0F0_1234);
    preload(3'd2, 32'h0FF0_FFFF);
    done_cycs.delete();
    issue(3'd1, 3'd2, 3'd5, 1'b0, 0);
    wait_idle();
    chk("and_mem5", mem[5], 32'h00F0_1234);
    chk("and_result", result_o, 32'h00F0_1234);
    chk("and_count", op_count_o, 1);
    chk("and_ndone", done_cycs.size(), 1);
    if (done_cycs.size() == 1) chk("and_latency", done_cycs[0] - acc_cyc, 4);

    // OR with overlap, then dependent command back-to-back
    preload(3'd3, 32'h0000_00FF);
    preload(3'd4, 32'hAB00_0000);
    issue(3'd3, 3'd4, 3'd3, 1'b1, 1);
    issue(3'd3, 3'd3, 3'd6, 1'b0, 0);
    wait_idle();
    chk("or_mem3", mem[3], 32'hAB00_00FF);
    chk("dep_mem6", mem[6], 32'hAB00_00FF);
    chk("or_count", op_count_o, 3);

    // Backpressure: three commands with valid held high throughout
    done_cycs.delete();
    issue(3'd0, 3'd1, 3'd2, 1'b1, 1);
    issue(3'd2, 3'd3, 3'd4, 1'b0, 1);
    issue(3'd4, 3'd5, 3'd0, 1'b1, 0);
    wait_idle();
    chk("bp_ndone", done_cycs.size(), 3);
    if (done_cycs.size() == 3) begin
      chk("bp_gap1", done_cycs[1] - done_cycs[0], 5);
      chk("bp_gap2", done_cycs[2] - done_cycs[1], 5);
    end

    // Randomized traffic
    for (int n = 0; n < 60; n++) begin
      issue(AW'($urandom), AW'($urandom), AW'($urandom), 1'($urandom), bit'($urandom_range(0, 1)));
      if (!ifc.cmd_valid) repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
    end
    ifc.cmd_valid = 1'b0;
    wait_idle();
    for (int i = 0; i < 8; i++) chk("rand_mem", mem[i], ref_mem[i]);

    // Counter wrap after 256 commands from reset
    do_reset();
    for (int n = 0; n < 256; n++) begin
      issue(AW'($urandom), AW'($urandom), AW'($urandom), 1'($urandom), n < 255);
      if (n == 255) chk("wrap_ff", op_count_o, 8'hFF);
    end
    wait_idle();
    chk("wrap_00", op_count_o, 8'h00);
    for (int i = 0; i < 8; i++) chk("wrap_mem", mem[i], ref_mem[i]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/op_cmd_sequencer.md
Name: op_cmd_sequencer

Overview:
- Command-driven controller that sits directly upstream of the 8x32 scratch memory and the AND/OR operation.
- Replaces the free-running counter-sequenced flow with a valid/ready command interface.
- Per command: read operand A, read operand B, compute A&B or A|B, write the result back to memory.
- Drives the memory's single address / write-data / write-enable port; consumes its combinational read data.

Parameters:
- DATA_W, 32, memory word and operand width
- ADDR_W, 3, memory address width (2**ADDR_W words)
- CNT_W, 8, width of completed-command counter

Ports:
- clk  in  1  single clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  sequencer accepts command this cycle
- cmd_a_addr  in  ADDR_W  operand A address
- cmd_b_addr  in  ADDR_W  operand B address
- cmd_c_addr  in  ADDR_W  result address
- cmd_mode  in  1  0 = AND, 1 = OR
- mem_addr  out  ADDR_W  memory address
- mem_rdata  in  DATA_W  memory read data, combinational from mem_addr
- mem_wdata  out  DATA_W  memory write data
- mem_wmode  out  1  memory write enable, write commits at clk edge
- done  out  1  one-cycle pulse, result written this cycle
- result  out  DATA_W  last computed result, held until next EXEC
- busy  out  1  state != IDLE
- op_count  out  CNT_W  completed commands, wraps modulo 2**CNT_W

Behaviour:
- Reset (async, immediate): state=IDLE.
  - Zeroed: command regs, a_reg, b_reg, result, op_count, done, mem_wmode, mem_addr, mem_wdata.
  - cmd_ready=0 while rst high.
- States: IDLE -> RD_A -> RD_B -> EXEC -> WR -> IDLE. No other transitions except reset.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid&cmd_ready: latch a/b/c addr and mode, go RD_A.
  - mem_addr=0, mem_wmode=0.
- RD_A: mem_addr=a_addr; a_reg<=mem_rdata at end of cycle; go RD_B.
- RD_B: mem_addr=b_addr; b_reg<=mem_rdata; go EXEC.
- EXEC:
  - result<= mode ? a_reg|b_reg : a_reg&b_reg (bitwise, DATA_W, no carry).
  - mem_addr=c_addr (early setup); go WR.
- WR:
  - mem_addr=c_addr, mem_wdata=result, mem_wmode=1, done=1.
  - op_count<=op_count+1 (wrap 0xFF->0x00); go IDLE.
- mem_wmode is high only in WR; never high in any other state.
- cmd_ready is low in all non-IDLE states. Commands presented while busy are held by the source; none are dropped.
- Latency:
  - Accept edge to done: 4 cycles.
  - Throughput: 1 command per 5 cycles (IDLE accept cycle included).
- Address overlap:
  - a_addr==b_addr is legal; both reads return the same word.
  - c_addr equal to a or b is legal; reads precede the write.
- Back-to-back dependency: a command accepted after done observes the written value, because the write committed at the WR edge.
- Reset mid-operation: the command is abandoned and no write occurs (mem_wmode drops asynchronously). op_count is not incremented.
- Command inputs are sampled only at the accept edge; later changes are ignored.
- Reads are combinational and the value is captured in the same cycle, so no read-latency wait states.

Decomposition:
- Shared package:
  - state enum (IDLE, RD_A, RD_B, EXEC, WR)
  - mode constants MODE_AND=0, MODE_OR=1
  - default DATA_W/ADDR_W
- One natural sub-module: op_alu, a combinational AND/OR of two DATA_W words selected by mode.
- FSM and registers stay in the top module.

Test Plan:
- Reset then idle: rst pulse -> all outputs 0; after release cmd_ready=1, busy=0, op_count=0.
- AND command: preload mem[1]=0xF0F0_1234, mem[2]=0x0FF0_FFFF; cmd a=1 b=2 c=5 mode=0 -> done 4 cycles after accept, mem[5]=0x00F0_1234, result=0x00F0_1234, op_count=1.
- OR with overlap: mem[3]=0x0000_00FF, mem[4]=0xAB00_0000; cmd a=3 b=4 c=3 mode=1 -> mem[3]=0xAB00_00FF; immediate next cmd a=3 b=3 c=6 mode=0 -> mem[6]=0xAB00_00FF.
- Backpressure: hold cmd_valid continuously with 3 distinct commands -> exactly 3 done pulses spaced 5 cycles apart, cmd_ready low while busy, mem_wmode high only in WR cycles.
- Reset mid-op: assert rst during RD_B -> mem_wmode never asserted, target word unchanged, op_count unchanged, state IDLE.
- Counter wrap: issue 256 commands -> op_count returns to 0x00 after the 256th done.
